// File: rtl/evt_weight_distributor.sv
// -----------------------------------------------------------------------------
// evt_weight_distributor
//
// Sits between the weight event stream and the slice stream inputs. In
// distribution mode it injects an engine header, waits for the first spike,
// replaces it with a time barrier, then sends an engine barrier and a weight
// header to every enabled slice. After that it deals weight words round-robin,
// in bursts, across the (possibly non-contiguous) slice mask until every
// enabled slice has received threshold words. In transparent mode the input
// is broadcast unchanged to the slices selected by enable_i.
//
// Event word layout (32 bit):
//   spike / barrier : [31:28] op, [27:24] cid, [23:16] yid, [15:8] xid, [7:0] unused
//   header          : [31:28] EVT_HDR, [27:24] gdst, [23:20] ldst,
//                     [19:16] option, [15:0] length
//
// Ports
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   module_enable_i   1: distribution mode, 0: transparent broadcast
//   enable_i          slice mask
//   threshold_i       weight words per slice
//   burst_len_i       words per slice turn (0 behaves as 1)
//   wgt_length_i      length field of the generated weight header
//   flush_i           abort the sequence, back to IDLE
//   busy_o            FSM not in IDLE
//   done_o            one-cycle pulse when distribution completes
//   cur_slice_o       slice being fed in DISTRIBUTE, 0 otherwise
//   evt_dst_*         input weight stream (valid/ready/data)
//   evt_src_*         per-slice output valid/ready, shared output data bus
// -----------------------------------------------------------------------------
module evt_weight_distributor #(
   parameter int SLICE_NUMBER  = 8,
   parameter int MAX_THRESHOLD = 256,
   parameter int MAX_BURST     = 8,
   localparam int TW = $clog2(MAX_THRESHOLD + 1),
   localparam int BW = $clog2(MAX_BURST + 1),
   localparam int SW = $clog2(SLICE_NUMBER)
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    module_enable_i,
   input  logic [SLICE_NUMBER-1:0] enable_i,
   input  logic [TW-1:0]           threshold_i,
   input  logic [BW-1:0]           burst_len_i,
   input  logic [15:0]             wgt_length_i,
   input  logic                    flush_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic [SW-1:0]           cur_slice_o,
   input  logic                    evt_dst_valid,
   output logic                    evt_dst_ready,
   input  logic [31:0]             evt_dst_data,
   output logic [SLICE_NUMBER-1:0] evt_src_valid,
   input  logic [SLICE_NUMBER-1:0] evt_src_ready,
   output logic [31:0]             evt_src_data
);

   localparam logic [3:0] EVT_SPIKE  = 4'h1;
   localparam logic [3:0] EVT_SYNCH  = 4'h2;
   localparam logic [3:0] EVT_EOP    = 4'h3;
   localparam logic [3:0] EVT_HDR    = 4'hF;
   localparam logic [3:0] DST_ENGINE = 4'h1;
   localparam logic [3:0] DST_MEMORY = 4'h2;
   localparam int         WW         = TW + BW;

   typedef enum logic [2:0] {
      IDLE, ENG_HDR, WAIT_SPIKE, TIME_BARRIER, ENG_BARRIER, WGT_HDR, DISTRIBUTE, DONE
   } state_t;

   function automatic logic [31:0] make_hdr(input logic [3:0] gdst, input logic [15:0] len);
      make_hdr = {EVT_HDR, gdst, 4'h0, 4'h0, len};
   endfunction

   function automatic logic [SW-1:0] lowest_bit(input logic [SLICE_NUMBER-1:0] m);
      lowest_bit = '0;
      for (int i = SLICE_NUMBER - 1; i >= 0; i--) begin
         if (m[i]) lowest_bit = SW'(i);
      end
   endfunction

   function automatic logic [SLICE_NUMBER-1:0] bits_above(input logic [SLICE_NUMBER-1:0] m,
                                                          input logic [SW-1:0] c);
      for (int i = 0; i < SLICE_NUMBER; i++) begin
         bits_above[i] = m[i] && (i > int'(c));
      end
   endfunction

   state_t                  state_q, state_d;
   logic [SLICE_NUMBER-1:0] en_q, en_d;
   logic [TW-1:0]           thr_q, thr_d;
   logic [BW-1:0]           burst_q, burst_d;
   logic [15:0]             wlen_q, wlen_d;
   logic [TW-1:0]           base_q, base_d;
   logic [BW-1:0]           beat_q, beat_d;
   logic [SW-1:0]           cur_q, cur_d;
   logic [SLICE_NUMBER-1:0] acked_q, acked_d;

   logic [SLICE_NUMBER-1:0] sel;
   logic                    out_v;
   logic [31:0]             out_data;
   logic                    fork_done;
   logic                    hs;
   logic                    is_spike;

   // burst bookkeeping, compared in a width wide enough for both counters
   logic [TW-1:0]           rem;
   logic [WW-1:0]           rem_w, burst_w, bsz_w, beat_nxt_w;
   logic [TW-1:0]           base_nxt;
   logic                    burst_last, seq_last;
   logic [SLICE_NUMBER-1:0] above;

   assign is_spike   = (evt_dst_data[31:28] == EVT_SPIKE);
   assign rem        = thr_q - base_q;
   assign rem_w      = {{BW{1'b0}}, rem};
   assign burst_w    = {{TW{1'b0}}, burst_q};
   assign bsz_w      = (burst_w < rem_w) ? burst_w : rem_w;
   assign beat_nxt_w = {{TW{1'b0}}, beat_q} + WW'(1);
   assign burst_last = (beat_nxt_w == bsz_w);
   assign base_nxt   = base_q + bsz_w[TW-1:0];
   assign seq_last   = (base_nxt == thr_q);
   assign above      = bits_above(en_q, cur_q);

   // Output selection and payload; independent of the handshake result.
   always_comb begin
      sel      = '0;
      out_v    = 1'b0;
      out_data = evt_dst_data;
      unique case (state_q)
         IDLE: begin
            if (!module_enable_i) begin
               sel   = enable_i;
               out_v = evt_dst_valid && (|enable_i);
            end
         end
         ENG_HDR: begin
            sel      = en_q;
            out_v    = 1'b1;
            out_data = make_hdr(DST_ENGINE, 16'hFFFF);
         end
         WAIT_SPIKE: begin
            sel   = en_q;
            out_v = evt_dst_valid && !is_spike;
         end
         TIME_BARRIER: begin
            sel      = en_q;
            out_v    = 1'b1;
            out_data = {EVT_SYNCH, 28'h0};
         end
         ENG_BARRIER: begin
            sel      = en_q;
            out_v    = 1'b1;
            out_data = {EVT_EOP, 28'h0};
         end
         WGT_HDR: begin
            sel      = en_q;
            out_v    = 1'b1;
            out_data = make_hdr(DST_MEMORY, wlen_q);
         end
         DISTRIBUTE: begin
            sel   = SLICE_NUMBER'(1) << cur_q;
            out_v = evt_dst_valid;
         end
         default: ;
      endcase
   end

   // Dynamic fork: a slice that has already taken the current event is masked
   // off until every selected slice has accepted it.
   assign fork_done     = &(~sel | acked_q | evt_src_ready);
   assign evt_src_valid = sel & ~acked_q & {SLICE_NUMBER{out_v}};
   assign evt_src_data  = out_data;
   assign hs            = out_v && fork_done;

   always_comb begin
      state_d       = state_q;
      en_d          = en_q;
      thr_d         = thr_q;
      burst_d       = burst_q;
      wlen_d        = wlen_q;
      base_d        = base_q;
      beat_d        = beat_q;
      cur_d         = cur_q;
      acked_d       = hs ? '0 : (acked_q | (evt_src_valid & evt_src_ready));
      evt_dst_ready = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (!module_enable_i) begin
               evt_dst_ready = (|enable_i) && fork_done;
            end else if (evt_dst_valid && (|enable_i)) begin
               state_d = ENG_HDR;
               en_d    = enable_i;
               thr_d   = threshold_i;
               burst_d = (burst_len_i == '0) ? BW'(1) : burst_len_i;
               wlen_d  = wgt_length_i;
            end
         end
         ENG_HDR: if (hs) state_d = WAIT_SPIKE;
         WAIT_SPIKE: begin
            if (evt_dst_valid && is_spike) begin
               // the spike itself is swallowed and replaced by the time barrier
               evt_dst_ready = 1'b1;
               state_d       = TIME_BARRIER;
            end else begin
               evt_dst_ready = fork_done;
            end
         end
         TIME_BARRIER: if (hs) state_d = ENG_BARRIER;
         ENG_BARRIER:  if (hs) state_d = WGT_HDR;
         WGT_HDR: begin
            if (hs) begin
               state_d = (thr_q == '0) ? DONE : DISTRIBUTE;
               cur_d   = lowest_bit(en_q);
               base_d  = '0;
               beat_d  = '0;
            end
         end
         DISTRIBUTE: begin
            evt_dst_ready = fork_done;
            if (hs) begin
               if (!burst_last) begin
                  beat_d = beat_q + BW'(1);
               end else if (|above) begin
                  cur_d  = lowest_bit(above);
                  beat_d = '0;
               end else if (seq_last) begin
                  state_d = DONE;
               end else begin
                  base_d = base_nxt;
                  cur_d  = lowest_bit(en_q);
                  beat_d = '0;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            en_d    = '0;
            thr_d   = '0;
            burst_d = '0;
            wlen_d  = '0;
            base_d  = '0;
            beat_d  = '0;
            cur_d   = '0;
         end
         default: state_d = IDLE;
      endcase

      if (flush_i) begin
         state_d = IDLE;
         en_d    = '0;
         thr_d   = '0;
         burst_d = '0;
         wlen_d  = '0;
         base_d  = '0;
         beat_d  = '0;
         cur_d   = '0;
         acked_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         en_q    <= '0;
         thr_q   <= '0;
         burst_q <= '0;
         wlen_q  <= '0;
         base_q  <= '0;
         beat_q  <= '0;
         cur_q   <= '0;
         acked_q <= '0;
      end else begin
         state_q <= state_d;
         en_q    <= en_d;
         thr_q   <= thr_d;
         burst_q <= burst_d;
         wlen_q  <= wlen_d;
         base_q  <= base_d;
         beat_q  <= beat_d;
         cur_q   <= cur_d;
         acked_q <= acked_d;
      end
   end

   assign busy_o      = (state_q != IDLE);
   assign done_o      = (state_q == DONE);
   assign cur_slice_o = (state_q == DISTRIBUTE) ? cur_q : '0;

endmodule

// File: tb/tb_evt_weight_distributor.sv
// -----------------------------------------------------------------------------
// tb_evt_weight_distributor
//
// Randomized bench for evt_weight_distributor. For each sequence it builds the
// input event list and, per slice, the list of events that slice must receive
// (headers, barriers and its share of weight words dealt round-robin in
// bursts). A monitor scoreboards every slice handshake against those lists.
// -----------------------------------------------------------------------------
module tb_evt_weight_distributor;

   localparam int N   = 8;
   localparam int TW  = 9;
   localparam int BW  = 4;
   localparam int MEM = 4096;

   logic          clk = 1'b0;
   logic          rst_ni = 1'b0;
   logic          module_enable_i;
   logic [N-1:0]  enable_i;
   logic [TW-1:0] threshold_i;
   logic [BW-1:0] burst_len_i;
   logic [15:0]   wgt_length_i;
   logic          flush_i;
   logic          busy_o, done_o;
   logic [2:0]    cur_slice_o;
   logic          dst_valid, dst_ready;
   logic [31:0]   dst_data;
   logic [N-1:0]  src_valid, src_ready;
   logic [31:0]   src_data;

   always #5 clk = ~clk;

   evt_weight_distributor #(.SLICE_NUMBER(N), .MAX_THRESHOLD(256), .MAX_BURST(8)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .module_enable_i(module_enable_i),
      .enable_i(enable_i), .threshold_i(threshold_i), .burst_len_i(burst_len_i),
      .wgt_length_i(wgt_length_i), .flush_i(flush_i), .busy_o(busy_o),
      .done_o(done_o), .cur_slice_o(cur_slice_o),
      .evt_dst_valid(dst_valid), .evt_dst_ready(dst_ready), .evt_dst_data(dst_data),
      .evt_src_valid(src_valid), .evt_src_ready(src_ready), .evt_src_data(src_data)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // stimulus and per-slice expectations
   logic [31:0] src_mem [MEM];
   int          wgt_sl  [MEM];
   int          src_n, src_idx;
   logic [31:0] exp_mem [N][MEM];
   int          head [N];
   int          tail [N];

   logic [N-1:0]  cfg_mask;
   logic [TW-1:0] cfg_thr;
   logic [BW-1:0] cfg_burst;
   logic [15:0]   cfg_wlen;
   logic [N-1:0]  bp_mask;
   int            bp_pct;
   bit            scramble;
   int            flush_at;
   bit            flush_pending;
   int            cyc, done_cnt, done_cyc, last_acc;

   always @(negedge clk) begin
      if (rst_ni) begin
         for (int i = 0; i < N; i++) begin
            if (src_valid[i] && src_ready[i]) begin
               chk($sformatf("s%0d_avail", i), 32'(head[i] < tail[i]), 32'd1);
               if (head[i] < tail[i]) begin
                  chk($sformatf("s%0d_data", i), src_data, exp_mem[i][head[i]]);
                  head[i]++;
               end
            end
         end
      end
   end

   task automatic push_src(input logic [31:0] w, input int sl);
      src_mem[src_n] = w;
      wgt_sl[src_n]  = sl;
      src_n++;
   endtask

   task automatic push_exp(input int s, input logic [31:0] w);
      exp_mem[s][tail[s]] = w;
      tail[s]++;
   endtask

   task automatic push_all(input logic [N-1:0] m, input logic [31:0] w);
      for (int s = 0; s < N; s++) if (m[s]) push_exp(s, w);
   endtask

   task automatic build(input logic [N-1:0] m, input int thr, input int burst,
                        input logic [15:0] wlen, input int nfill);
      int b, base, bsz;
      logic [31:0] w;
      src_n = 0;
      src_idx = 0;
      push_all(m, {4'hF, 4'h1, 4'h0, 4'h0, 16'hFFFF});
      for (int f = 0; f < nfill; f++) begin
         w = $urandom;
         if (w[31:28] == 4'h1) w[31:28] = 4'h6;
         push_src(w, -1);
         push_all(m, w);
      end
      push_src({4'h1, 28'($urandom)}, -1);
      push_all(m, {4'h2, 28'h0});
      push_all(m, {4'h3, 28'h0});
      push_all(m, {4'hF, 4'h2, 4'h0, 4'h0, wlen});
      b = (burst == 0) ? 1 : burst;
      base = 0;
      while (base < thr) begin
         bsz = (b < thr - base) ? b : thr - base;
         for (int s = 0; s < N; s++) begin
            if (m[s]) begin
               for (int k = 0; k < bsz; k++) begin
                  w = $urandom;
                  push_src(w, s);
                  push_exp(s, w);
               end
            end
         end
         base += bsz;
      end
   endtask

   task automatic run(input int budget, input bit want_done);
      int  n;
      bit  flushed;
      n = 0;
      flushed = 0;
      done_cnt = 0;
      done_cyc = -1;
      last_acc = -1;
      flush_pending = 0;
      while (n < budget) begin
         @(posedge clk); #1;
         flush_i = 1'b0;
         if (scramble && busy_o) begin
            enable_i     = 8'($urandom);
            threshold_i  = 9'($urandom);
            burst_len_i  = 4'($urandom);
            wgt_length_i = 16'($urandom);
         end else begin
            enable_i     = cfg_mask;
            threshold_i  = cfg_thr;
            burst_len_i  = cfg_burst;
            wgt_length_i = cfg_wlen;
         end
         if (flush_pending) begin
            flush_i   = 1'b1;
            dst_valid = 1'b0;
            flushed   = 1;
         end else begin
            dst_valid = (src_idx < src_n);
            dst_data  = src_mem[src_idx];
         end
         for (int i = 0; i < N; i++)
            src_ready[i] = bp_mask[i] ? ($urandom_range(99) >= bp_pct) : 1'b1;
         @(negedge clk);
         cyc++;
         if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (dst_valid && dst_ready) begin
            if (wgt_sl[src_idx] >= 0) chk("cur_slice", 32'(cur_slice_o), wgt_sl[src_idx]);
            last_acc = cyc;
            src_idx++;
            if (src_idx == flush_at) flush_pending = 1;
         end
         if (flushed) break;
         if (src_idx == src_n && (!want_done || done_cnt > 0)) break;
         n++;
      end
      if (!flushed) chk("all_accepted", src_idx, src_n);
   endtask

   task automatic check_drain();
      for (int i = 0; i < N; i++) chk($sformatf("s%0d_drain", i), head[i], tail[i]);
   endtask

   task automatic do_seq(input logic [N-1:0] m, input int thr, input int burst,
                         input logic [15:0] wlen, input int nfill,
                         input logic [N-1:0] bpm, input int pct, input bit scr);
      cfg_mask  = m;
      cfg_thr   = 9'(thr);
      cfg_burst = 4'(burst);
      cfg_wlen  = wlen;
      bp_mask   = bpm;
      bp_pct    = pct;
      scramble  = scr;
      build(m, thr, burst, wlen, nfill);
      run(3000, 1);
      chk("done_once", done_cnt, 1);
      if (thr > 0) chk("done_lat", done_cyc, last_acc + 1);
      @(posedge clk); #1;
      dst_valid = 1'b0;
      @(negedge clk);
      chk("busy_after", 32'(busy_o), 32'd0);
      chk("done_pulse", 32'(done_o), 32'd0);
      check_drain();
   endtask

   initial begin
      module_enable_i = 1'b1;
      enable_i = '0;
      threshold_i = '0;
      burst_len_i = '0;
      wgt_length_i = '0;
      flush_i = 1'b0;
      dst_valid = 1'b0;
      dst_data = '0;
      src_ready = '1;
      flush_at = -1;
      cyc = 0;
      for (int i = 0; i < N; i++) begin
         head[i] = 0;
         tail[i] = 0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_cur", 32'(cur_slice_o), 32'd0);
      @(posedge clk); #1;
      rst_ni = 1'b1;

      do_seq(8'h0F, 4, 2, 16'd16, 0, 8'h00, 0, 0);
      do_seq(8'hA5, 3, 2, 16'd12, 1, 8'h00, 0, 0);
      do_seq(8'h10, 5, 1, 16'd5, 0, 8'h00, 0, 0);
      do_seq(8'hFF, 4, 3, 16'h0040, 2, 8'h04, 60, 0);
      do_seq(8'h81, 0, 2, 16'h1234, 1, 8'h00, 0, 0);
      do_seq(8'h42, 3, 0, 16'h0003, 0, 8'h42, 30, 1);

      // abort in the middle of dealing, then a clean restart
      cfg_mask = 8'h0F; cfg_thr = 9'd4; cfg_burst = 4'd2; cfg_wlen = 16'd16;
      bp_mask = 8'h00; bp_pct = 0; scramble = 0;
      build(8'h0F, 4, 2, 16'd16, 0);
      flush_at = 1 + 6;
      run(3000, 1);
      flush_at = -1;
      src_idx = src_n;
      @(posedge clk); #1;
      flush_i = 1'b0;
      dst_valid = 1'b0;
      @(negedge clk);
      chk("flush_busy", 32'(busy_o), 32'd0);
      chk("flush_done", 32'(done_o), 32'd0);
      chk("flush_no_done", done_cnt, 0);
      chk("flush_words", head[1], tail[1] - 2);
      for (int i = 0; i < N; i++) tail[i] = head[i];
      do_seq(8'h0F, 2, 2, 16'd8, 0, 8'h00, 0, 0);

      for (int r = 0; r < 6; r++) begin
         do_seq(8'($urandom_range(1, 255)), $urandom_range(0, 6), $urandom_range(0, 4),
                16'($urandom), $urandom_range(0, 3), 8'($urandom), 30, 1);
      end

      // transparent broadcast
      module_enable_i = 1'b0;
      cfg_mask = 8'h03; cfg_thr = '0; cfg_burst = '0; cfg_wlen = '0;
      bp_mask = 8'h02; bp_pct = 40; scramble = 0;
      src_n = 0;
      src_idx = 0;
      for (int k = 0; k < 10; k++) begin
         logic [31:0] w;
         w = $urandom;
         push_src(w, -1);
         push_all(8'h03, w);
      end
      run(1000, 0);
      @(posedge clk); #1;
      dst_valid = 1'b0;
      @(negedge clk);
      check_drain();
      @(posedge clk); #1;
      enable_i = '0;
      dst_valid = 1'b1;
      dst_data = 32'hDEAD_BEEF;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("mask0_ready", 32'(dst_ready), 32'd0);
         chk("mask0_valid", 32'(src_valid), 32'd0);
      end
      @(posedge clk); #1;
      dst_valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
